debug_mux_ctrl: RTL and testbench

//  Drives the _mux_sel_* / *_mux_input_ ports of a debug-instrumented GTECH netlist,

---
 rtl/debug_mux_pkg.sv | 25 ++
 rtl/dbg_shift_reg.sv | 82 ++++++++
 rtl/debug_mux_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_debug_mux_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_mux_pkg.sv
// Shared definitions for the debug mux controller.
//   dbg_op_t           command encoding carried on cmd_op
//   dbg_state_t        controller FSM states
//   DBG_MUX_SEL_INJECT mux_sel level that selects the injected value
package debug_mux_pkg;

  typedef enum logic [1:0] {
    OP_LOAD    = 2'd0,
    OP_APPLY   = 2'd1,
    OP_CAPTURE = 2'd2,
    OP_CLEAR   = 2'd3
  } dbg_op_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SHIFT_IN  = 3'd1,
    ST_APPLY     = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_SHIFT_OUT = 3'd4
  } dbg_state_t;

  // A mux site passes its injected value when its select is at this level.
  localparam logic DBG_MUX_SEL_INJECT = 1'b1;

endpackage

// File: rtl/dbg_shift_reg.sv
// Serial-in / serial-out register with a saturating bit counter.
// The counter points at the bit being written (serial in) or shown (serial out).
//   clk, rst    clock and synchronous active-high reset (clears data and counter)
//   clr         restart the counter at bit 0, data kept
//   load        parallel load of load_data, counter restarts at bit 0
//   sin_en, si  write si into data[cnt], then advance the counter
//   adv         advance the counter without writing
//   data        current register contents
//   so_next     bit at position cnt+1 (the bit shown after the next advance)
//   last        counter is at the top bit
//   next_last   counter is one below the top bit
module dbg_shift_reg #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             sin_en,
  input  logic             si,
  input  logic             adv,
  output logic [WIDTH-1:0] data,
  output logic             so_next,
  output logic             last,
  output logic             next_last
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] data_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc   = cnt_reg + 1'b1;
  assign last      = (cnt_reg == CNT_MAX);
  assign next_last = (cnt_inc == CNT_MAX);
  assign data      = data_reg;

  // Per-bit write enable decoded from the counter: only the addressed bit
  // takes si, so a stalled beat (sin_en low) leaves every bit untouched.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign data_next[gi] = load ? load_data[gi] :
                             ((sin_en && (cnt_reg == CNT_W'(gi))) ? si : data_reg[gi]);
    end
  endgenerate

  // Counter saturates at the top bit so extra beats cannot wrap it back to 0.
  always_comb begin
    cnt_next = cnt_reg;
    if (clr || load) begin
      cnt_next = '0;
    end else if ((sin_en || adv) && !last) begin
      cnt_next = cnt_inc;
    end
  end

  always_comb begin
    so_next = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt_inc == CNT_W'(i)) begin
        so_next = data_reg[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      data_reg <= data_next;
      cnt_reg  <= cnt_next;
    end
  end

endmodule

// File: rtl/debug_mux_ctrl.sv
// Debug mux controller for a debug-instrumented netlist. Each instrumented gate
// output feeds a MUX2 (sel=0 original, sel=1 injected). Patterns are loaded
// serially into a shadow register and applied atomically; original gate values
// are captured and read out serially.
//   clk, rst             clock and synchronous active-high reset
//   cmd_valid/op/ready   command handshake (LOAD, APPLY, CAPTURE, CLEAR)
//   si, si_valid         serial pattern input, LSB first: N values then N selects
//   so, so_valid         serial capture output, LSB first
//   done                 one-cycle pulse when a command completes
//   mux_sel, mux_input   drive the instrumented mux selects and injected values
//   obs                  original gate values, sampled only in CAPTURE
module debug_mux_ctrl
  import debug_mux_pkg::*;
#(
  parameter int N_SITES = 8,
  parameter int CNT_W   = $clog2(2 * N_SITES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd_op,
  output logic               cmd_ready,
  input  logic               si,
  input  logic               si_valid,
  output logic               so,
  output logic               so_valid,
  output logic               done,
  output logic [N_SITES-1:0] mux_sel,
  output logic [N_SITES-1:0] mux_input,
  input  logic [N_SITES-1:0] obs
);

  dbg_state_t         state_reg;
  logic [N_SITES-1:0] mux_sel_reg;
  logic [N_SITES-1:0] mux_input_reg;
  logic               so_reg;
  logic               so_valid_reg;
  logic               done_reg;

  dbg_op_t            op;
  logic               accept;

  logic [2*N_SITES-1:0] shadow_data;
  logic                 shadow_last;
  logic                 shadow_so_next_unused;
  logic                 shadow_next_last_unused;
  logic                 shadow_clr;
  logic                 shadow_sin;

  logic [N_SITES-1:0]   capture_data_unused;
  logic                 capture_so_next;
  logic                 capture_last;
  logic                 capture_next_last;
  logic                 capture_load;
  logic                 capture_adv;

  assign op        = dbg_op_t'(cmd_op);
  assign cmd_ready = (state_reg == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;

  assign mux_sel   = mux_sel_reg;
  assign mux_input = mux_input_reg;
  assign so        = so_reg;
  assign so_valid  = so_valid_reg;
  assign done      = done_reg;

  // Every LOAD restarts at bit 0; the shadow contents themselves are simply
  // overwritten beat by beat, so a completed LOAD always replaces all bits.
  assign shadow_clr = accept && (op == OP_LOAD);
  assign shadow_sin = (state_reg == ST_SHIFT_IN) && si_valid;

  assign capture_load = (state_reg == ST_CAPTURE);
  assign capture_adv  = (state_reg == ST_SHIFT_OUT);

  dbg_shift_reg #(
    .WIDTH (2 * N_SITES),
    .CNT_W (CNT_W)
  ) u_shadow (
    .clk       (clk),
    .rst       (rst),
    .clr       (shadow_clr),
    .load      (1'b0),
    .load_data ('0),
    .sin_en    (shadow_sin),
    .si        (si),
    .adv       (1'b0),
    .data      (shadow_data),
    .so_next   (shadow_so_next_unused),
    .last      (shadow_last),
    .next_last (shadow_next_last_unused)
  );

  dbg_shift_reg #(
    .WIDTH (N_SITES),
    .CNT_W (CNT_W)
  ) u_capture (
    .clk       (clk),
    .rst       (rst),
    .clr       (1'b0),
    .load      (capture_load),
    .load_data (obs),
    .sin_en    (1'b0),
    .si        (1'b0),
    .adv       (capture_adv),
    .data      (capture_data_unused),
    .so_next   (capture_so_next),
    .last      (capture_last),
    .next_last (capture_next_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      mux_sel_reg   <= '0;
      mux_input_reg <= '0;
      so_reg        <= 1'b0;
      so_valid_reg  <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            case (op)
              OP_LOAD:    state_reg <= ST_SHIFT_IN;
              OP_APPLY:   state_reg <= ST_APPLY;
              OP_CAPTURE: state_reg <= ST_CAPTURE;
              OP_CLEAR: begin
                // Return the netlist to transparent; the shadow is kept.
                mux_sel_reg   <= '0;
                mux_input_reg <= '0;
                done_reg      <= 1'b1;
              end
              default: ;
            endcase
          end
        end

        ST_SHIFT_IN: begin
          if (si_valid && shadow_last) begin
            state_reg <= ST_IDLE;
            done_reg  <= 1'b1;
          end
        end

        ST_APPLY: begin
          // Values and selects change on the same edge so the netlist never
          // sees a half-applied pattern.
          mux_input_reg <= shadow_data[N_SITES-1:0];
          mux_sel_reg   <= shadow_data[2*N_SITES-1:N_SITES];
          done_reg      <= 1'b1;
          state_reg     <= ST_IDLE;
        end

        ST_CAPTURE: begin
          // obs[0] goes straight to so on the capture edge so the first bit is
          // visible in the first SHIFT_OUT cycle.
          so_reg       <= obs[0];
          so_valid_reg <= 1'b1;
          done_reg     <= (N_SITES == 1);
          state_reg    <= ST_SHIFT_OUT;
        end

        ST_SHIFT_OUT: begin
          if (capture_last) begin
            so_reg       <= 1'b0;
            so_valid_reg <= 1'b0;
            state_reg    <= ST_IDLE;
          end else begin
            // done rides along with the final bit.
            so_reg   <= capture_so_next;
            done_reg <= capture_next_last;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_mux_ctrl.sv
// Self-checking bench for debug_mux_ctrl with N_SITES=8.
module tb_debug_mux_ctrl;
  import debug_mux_pkg::*;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic [1:0]   cmd_op;
  logic         cmd_ready;
  logic         si;
  logic         si_valid;
  logic         so;
  logic         so_valid;
  logic         done;
  logic [N-1:0] mux_sel;
  logic [N-1:0] mux_input;
  logic [N-1:0] obs;

  int n_cmp = 0;
  int n_err = 0;

  // Bench model of what is currently driven onto the muxes.
  logic [N-1:0] sel_m;
  logic [N-1:0] in_m;

  // Scoreboards: expected APPLY result {sel, input}, expected serial bits.
  logic [2*N-1:0] apply_q[$];
  logic           so_q[$];

  typedef struct {
    logic [N-1:0] vals;
    logic [N-1:0] sels;
    logic [N-1:0] obs_v;
    logic [N-1:0] exp_sel;
    logic [N-1:0] exp_input;
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  debug_mux_ctrl #(.N_SITES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_ready (cmd_ready),
    .si        (si),
    .si_valid  (si_valid),
    .so        (so),
    .so_valid  (so_valid),
    .done      (done),
    .mux_sel   (mux_sel),
    .mux_input (mux_input),
    .obs       (obs)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
    sel_m = '0;
    in_m  = '0;
    apply_q.delete();
    so_q.delete();
    check("rst_sel", mux_sel, 0);
    check("rst_input", mux_input, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_so_valid", so_valid, 0);
    check("rst_done", done, 0);
  endtask

  task automatic issue(input dbg_op_t op);
    check("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic load(input logic [N-1:0] vals, input logic [N-1:0] sels, input bit gap);
    logic [2*N-1:0] pat;
    pat = {sels, vals};
    issue(OP_LOAD);
    for (int i = 0; i < 2 * N; i++) begin
      si       = pat[i];
      si_valid = 1'b1;
      tick();
      check("load_done", done, (i == 2 * N - 1));
      check("load_ready", cmd_ready, (i == 2 * N - 1));
      check("load_sel_hold", mux_sel, sel_m);
      check("load_input_hold", mux_input, in_m);
      if (gap && i < 2 * N - 1) begin
        si_valid = 1'b0;
        si       = ~pat[i];
        tick();
        check("stall_done", done, 0);
        check("stall_ready", cmd_ready, 0);
      end
    end
    si_valid = 1'b0;
    tick();
    check("load_done_clear", done, 0);
  endtask

  task automatic apply(input logic [N-1:0] exp_sel, input logic [N-1:0] exp_in);
    logic [2*N-1:0] e;
    apply_q.push_back({exp_sel, exp_in});
    issue(OP_APPLY);
    check("apply_pending_sel", mux_sel, sel_m);
    check("apply_pending_done", done, 0);
    tick();
    e = apply_q.pop_front();
    check("apply_done", done, 1);
    check("apply_sel", mux_sel, e[2*N-1:N]);
    check("apply_input", mux_input, e[N-1:0]);
    sel_m = e[2*N-1:N];
    in_m  = e[N-1:0];
    tick();
    check("apply_done_clear", done, 0);
  endtask

  // pulse_at >= 0 strobes a CLEAR command in that cycle of the readout.
  task automatic capture(input logic [N-1:0] obs_v, input int pulse_at);
    int   seen;
    logic b;
    seen = 0;
    obs  = obs_v;
    for (int k = 0; k < N; k++) so_q.push_back(obs_v[k]);
    issue(OP_CAPTURE);
    check("capture_so_valid", so_valid, 0);
    for (int c = 0; c < 3 * N; c++) begin
      if (c == pulse_at) begin
        cmd_valid = 1'b1;
        cmd_op    = OP_CLEAR;
      end
      tick();
      cmd_valid = 1'b0;
      if (so_valid) begin
        seen++;
        if (so_q.size() > 0) begin
          b = so_q.pop_front();
          check("so_bit", so, b);
          check("so_done", done, (so_q.size() == 0));
        end
        check("so_ready", cmd_ready, 0);
      end else begin
        check("so_idle_done", done, 0);
        if (seen > 0) begin
          check("so_end_ready", cmd_ready, 1);
          break;
        end
      end
    end
    check("so_valid_count", seen, N);
    check("so_queue_empty", so_q.size(), 0);
    check("capture_sel_hold", mux_sel, sel_m);
    check("capture_input_hold", mux_input, in_m);
    so_q.delete();
  endtask

  task automatic clear();
    issue(OP_CLEAR);
    check("clear_sel", mux_sel, 0);
    check("clear_input", mux_input, 0);
    check("clear_done", done, 1);
    sel_m = '0;
    in_m  = '0;
    tick();
    check("clear_done_clear", done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    si        = 1'b0;
    si_valid  = 1'b0;
    obs       = '0;
    sel_m     = '0;
    in_m      = '0;

    vecs[0] = '{vals: 8'hA5, sels: 8'h0F, obs_v: 8'h3C, exp_sel: 8'h0F, exp_input: 8'hA5};
    vecs[1] = '{vals: 8'h00, sels: 8'hFF, obs_v: 8'hFF, exp_sel: 8'hFF, exp_input: 8'h00};
    vecs[2] = '{vals: 8'hFF, sels: 8'h00, obs_v: 8'h01, exp_sel: 8'h00, exp_input: 8'hFF};
    vecs[3] = '{vals: 8'h96, sels: 8'h69, obs_v: 8'h80, exp_sel: 8'h69, exp_input: 8'h96};

    // Reset, then idle with no commands.
    do_reset(3);
    for (int c = 0; c < 6; c++) begin
      tick();
      check("idle_sel", mux_sel, 0);
      check("idle_input", mux_input, 0);
      check("idle_ready", cmd_ready, 1);
      check("idle_so_valid", so_valid, 0);
    end

    // Table: LOAD, APPLY, CAPTURE per record.
    for (int v = 0; v < 4; v++) begin
      load(vecs[v].vals, vecs[v].sels, 1'b0);
      apply(vecs[v].exp_sel, vecs[v].exp_input);
      capture(vecs[v].obs_v, -1);
    end

    // LOAD with si_valid alternating 1,0; stalled cycles carry inverted data.
    load(8'h3C, 8'hC3, 1'b1);
    apply(8'hC3, 8'h3C);

    // Repeated APPLY re-applies the retained shadow.
    apply(8'hC3, 8'h3C);

    // Reset after 5 LOAD bits: the partial shadow must be discarded.
    issue(OP_LOAD);
    for (int i = 0; i < 5; i++) begin
      si       = 1'b1;
      si_valid = 1'b1;
      tick();
      check("partial_sel_hold", mux_sel, 8'hC3);
    end
    si_valid = 1'b0;
    do_reset(1);
    apply(8'h00, 8'h00);

    // Fresh LOAD after reset, then CLEAR and a command during SHIFT_OUT.
    load(8'h5A, 8'hFF, 1'b0);
    apply(8'hFF, 8'h5A);
    capture(8'h3C, 3);
    clear();
    apply(8'hFF, 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
